// File: rtl/mod_switches_pkg.sv
// Shared definitions for the switch/button peripheral: register offsets
// decoded from daddr[3:2] and a constant-width helper.
package mod_switches_pkg;

  localparam logic [1:0] SW_STATE  = 2'd0;
  localparam logic [1:0] BTN_STATE = 2'd1;
  localparam logic [1:0] BTN_PRESS = 2'd2;
  localparam logic [1:0] IRQ_EN    = 2'd3;

  // Ceiling log2, usable in constant expressions (returns 0 for value <= 1).
  function automatic int CLOG2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_switches_debounce_cell.sv
// One input bit: two-flop synchroniser followed by a stability counter.
// A change on the synchronised input is accepted only after it has been
// seen for DEBOUNCE_CYCLES consecutive cycles; any return to the current
// stable value restarts the count. o_rise pulses for one cycle on the
// same edge that the stable value goes 0->1.
module debounce_cell
  import mod_switches_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);

  localparam int              CW = CLOG2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_st;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc     = (r_cnt == TC);
  assign o_stable = r_st;
  assign o_rise   = r_rise;

  // Synchronise the raw pin and qualify changes with the stability counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_st   <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync == r_st) begin
        r_cnt <= '0;
      end else if (w_tc) begin
        r_st   <= r_sync;
        r_cnt  <= '0;
        r_rise <= r_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mod_switches.sv
// Memory-mapped input peripheral for slide switches and pushbuttons.
// Inputs are debounced on posedge; bus-visible registers (press flags,
// interrupt enables, irq) update on negedge, matching the CPU bus timing.
module mod_switches
  import mod_switches_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NSW             = 8,
  parameter int NBTN            = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_de,
  input  logic [31:0]     i_daddr,
  input  logic            i_drw,
  input  logic [31:0]     i_din,
  output logic [31:0]     o_dout,
  input  logic [NSW-1:0]  i_sw,
  input  logic [NBTN-1:0] i_btn,
  output logic            o_irq
);

  logic [NSW-1:0]  w_sw_st;
  logic [NSW-1:0]  w_sw_rise;
  logic [NBTN-1:0] w_btn_st;
  logic [NBTN-1:0] w_btn_rise;
  logic [1:0]      w_off;
  logic            w_wr;

  logic [NBTN-1:0] r_press;
  logic [NBTN-1:0] r_irq_en;
  logic            r_irq;

  assign w_off = i_daddr[3:2];
  assign w_wr  = i_de && i_drw;
  assign o_irq = r_irq;

  // Switch rise pulses exist only because the cell is shared; switches
  // have no press latch.
  for (genvar g = 0; g < NSW; g++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (i_sw[g]),
      .o_stable (w_sw_st[g]),
      .o_rise   (w_sw_rise[g])
    );
  end

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (i_btn[g]),
      .o_stable (w_btn_st[g]),
      .o_rise   (w_btn_rise[g])
    );
  end

  // Bus-side registers: sticky press flags (set beats W1C), enables, irq.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_press  <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= |(r_press & r_irq_en);
      if (w_wr && (w_off == BTN_PRESS)) begin
        r_press <= (r_press & ~i_din[NBTN-1:0]) | w_btn_rise;
      end else begin
        r_press <= r_press | w_btn_rise;
      end
      if (w_wr && (w_off == IRQ_EN)) begin
        r_irq_en <= i_din[NBTN-1:0];
      end
    end
  end

  // Combinational read mux; zero when the device is not selected.
  always_comb begin
    o_dout = 32'h0;
    if (i_de) begin
      case (w_off)
        SW_STATE:  o_dout = 32'(w_sw_st);
        BTN_STATE: o_dout = 32'(w_btn_st);
        BTN_PRESS: o_dout = 32'(r_press);
        IRQ_EN:    o_dout = 32'(r_irq_en);
        default:   o_dout = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_switches.sv
// Directed bench for mod_switches with a short debounce window (4 cycles),
// so an accepted change appears 6 posedges after the raw edge.
module tb_mod_switches;
  import mod_switches_pkg::*;

  localparam int DC   = 4;
  localparam int NSW  = 8;
  localparam int NBTN = 4;

  logic            clk;
  logic            rst;
  logic            de;
  logic [31:0]     daddr;
  logic            drw;
  logic [31:0]     din;
  logic [31:0]     dout;
  logic [NSW-1:0]  sw;
  logic [NBTN-1:0] btn;
  logic            irq;

  int n_checks = 0;
  int n_err    = 0;

  mod_switches #(
    .DEBOUNCE_CYCLES(DC),
    .NSW(NSW),
    .NBTN(NBTN)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_de    (de),
    .i_daddr (daddr),
    .i_drw   (drw),
    .i_din   (din),
    .o_dout  (dout),
    .i_sw    (sw),
    .i_btn   (btn),
    .o_irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance n posedges, leaving time 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp_v);
    de    = 1'b1;
    drw   = 1'b0;
    daddr = {28'h0, off, 2'b00};
    #1;
    chk(tag, dout, exp_v);
    de    = 1'b0;
    daddr = 32'h0;
  endtask

  // Write lands on the next negedge; returns 1 ns after it.
  task automatic bus_wr(input logic [1:0] off, input logic [31:0] data);
    de    = 1'b1;
    drw   = 1'b1;
    daddr = {28'h0, off, 2'b00};
    din   = data;
    @(negedge clk);
    #1;
    de    = 1'b0;
    drw   = 1'b0;
    daddr = 32'h0;
    din   = 32'h0;
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; daddr = 32'h0; drw = 1'b0; din = 32'h0;
    sw = '0; btn = '0;

    // Reset state
    tick(2);
    rd_chk("rst_sw",    SW_STATE,  32'h0);
    rd_chk("rst_btn",   BTN_STATE, 32'h0);
    rd_chk("rst_press", BTN_PRESS, 32'h0);
    rd_chk("rst_irqen", IRQ_EN,    32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // Switch debounce latency and glitch rejection
    sw = 8'hA5;
    tick(5);
    rd_chk("sw_early", SW_STATE, 32'h0);
    tick(1);
    rd_chk("sw_a5", SW_STATE, 32'h0000_00A5);
    de = 1'b0; daddr = 32'h0; #1;
    chk("de0_dout", dout, 32'h0);
    sw = 8'h00;
    tick(3);
    sw = 8'hA5;
    tick(8);
    rd_chk("sw_glitch", SW_STATE, 32'h0000_00A5);
    bus_wr(SW_STATE, 32'hFF);
    rd_chk("sw_wr_ign", SW_STATE, 32'h0000_00A5);

    // Button short pulse rejected, long press latched
    btn = 4'h4;
    tick(2);
    btn = 4'h0;
    tick(8);
    rd_chk("btn_pulse_st", BTN_STATE, 32'h0);
    rd_chk("btn_pulse_pr", BTN_PRESS, 32'h0);
    btn = 4'h4;
    tick(8);
    rd_chk("btn_held_st", BTN_STATE, 32'h4);
    rd_chk("btn_held_pr", BTN_PRESS, 32'h4);
    btn = 4'h0;
    tick(8);
    rd_chk("btn_rel_st", BTN_STATE, 32'h0);
    rd_chk("btn_rel_pr", BTN_PRESS, 32'h4);

    // W1C and set-wins collision
    bus_wr(BTN_PRESS, 32'h4);
    rd_chk("w1c_clr", BTN_PRESS, 32'h0);
    btn = 4'h4;
    tick(6);
    bus_wr(BTN_PRESS, 32'h4);
    rd_chk("set_wins", BTN_PRESS, 32'h4);
    bus_wr(BTN_PRESS, 32'h0);
    rd_chk("w0_keep", BTN_PRESS, 32'h4);
    bus_wr(BTN_PRESS, 32'hB);
    rd_chk("w1c_other", BTN_PRESS, 32'h4);
    bus_wr(BTN_PRESS, 32'h4);
    rd_chk("w1c_held", BTN_PRESS, 32'h0);
    btn = 4'h0;
    tick(8);

    // Interrupt enable, timing, clear and mask
    bus_wr(IRQ_EN, 32'h1);
    rd_chk("irqen_rd", IRQ_EN, 32'h1);
    btn = 4'h1;
    tick(6);
    chk("irq_pre", {31'h0, irq}, 32'h0);
    rd_chk("press_pre", BTN_PRESS, 32'h0);
    @(negedge clk); #1;
    rd_chk("press_set", BTN_PRESS, 32'h1);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clk); #1;
    chk("irq_set", {31'h0, irq}, 32'h1);
    bus_wr(BTN_PRESS, 32'h1);
    rd_chk("irq_w1c_pr", BTN_PRESS, 32'h0);
    chk("irq_w1c_lag", {31'h0, irq}, 32'h1);
    @(negedge clk); #1;
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    btn = 4'h0;
    tick(8);
    btn = 4'h1;
    tick(8);
    chk("irq_again", {31'h0, irq}, 32'h1);
    bus_wr(IRQ_EN, 32'h0);
    chk("mask_lag", {31'h0, irq}, 32'h1);
    @(negedge clk); #1;
    chk("irq_masked", {31'h0, irq}, 32'h0);
    rd_chk("mask_press", BTN_PRESS, 32'h1);
    bus_wr(IRQ_EN, 32'hFFFF_FFF0);
    rd_chk("irqen_upper", IRQ_EN, 32'h0);
    btn = 4'h0;
    tick(8);
    bus_wr(BTN_PRESS, 32'hF);
    rd_chk("pre6_press", BTN_PRESS, 32'h0);

    // Reset mid-count with button held through it
    btn = 4'h2;
    tick(3);
    rst = 1'b1;
    tick(2);
    rd_chk("inrst_sw", SW_STATE, 32'h0);
    rst = 1'b0;
    tick(5);
    rd_chk("r5_press", BTN_PRESS, 32'h0);
    rd_chk("r5_btn",   BTN_STATE, 32'h0);
    rd_chk("r5_sw",    SW_STATE,  32'h0);
    tick(1);
    rd_chk("r6_btn",   BTN_STATE, 32'h2);
    rd_chk("r6_sw",    SW_STATE,  32'h0000_00A5);
    rd_chk("r6_press", BTN_PRESS, 32'h0);
    @(negedge clk); #1;
    rd_chk("r6_press_set", BTN_PRESS, 32'h2);
    chk("r6_irq", {31'h0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
